// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with occupancy count, programmable almost flags, optional
// first-word-fall-through read path, synchronous flush and sticky error flags.
module sync_fifo_param #(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 1
) (
  input  logic                     clk_1,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [DATA_W-1:0]        data_1,
  input  logic                     data_1_en,
  input  logic                     data_2_rd,
  output logic [DATA_W-1:0]        data_2,
  output logic                     data_2_valid,
  output logic                     buffer_empty,
  output logic                     buffer_full,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wp;
  logic [AW-1:0]     rp;
  logic              rd_ok;
  logic              wr_acc;
  logic              rd_acc;

  assign buffer_empty = (count == '0);
  assign buffer_full  = (count == CW'(DEPTH));
  assign almost_full  = (int'(count) >= AF_LEVEL);
  assign almost_empty = (int'(count) <= AE_LEVEL);

  // flush swallows any request issued in the same cycle
  assign wr_acc = data_1_en & ~buffer_full & ~flush;
  assign rd_acc = data_2_rd & rd_ok & ~flush;

  always_ff @(posedge clk_1) begin
    if (wr_acc) mem[wp] <= data_1;
  end

  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr_acc) wp <= wp + AW'(1);
      if (rd_acc) rp <= rp + AW'(1);
      if (wr_acc && !rd_acc)      count <= count + CW'(1);
      else if (rd_acc && !wr_acc) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (!flush) begin
      if (data_1_en && buffer_full)  overflow  <= 1'b1;
      if (data_2_rd && buffer_empty) underflow <= 1'b1;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is forced to zero while empty so the output matches the
      // reset value rather than exposing unreset storage.
      assign data_2       = buffer_empty ? '0 : mem[rp];
      assign data_2_valid = ~buffer_empty;
      assign rd_ok        = data_2_valid;
    end else begin : g_reg
      assign rd_ok = ~buffer_empty;
      always_ff @(posedge clk_1 or posedge rst) begin
        if (rst) begin
          data_2       <= '0;
          data_2_valid <= 1'b0;
        end else begin
          data_2_valid <= rd_acc;
          if (rd_acc) data_2 <= mem[rp];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: one FWFT instance and one registered-read
// instance, each checked against a queue model of contents and flags.
module tb_sync_fifo_param;

  logic clk_1 = 1'b0;
  logic rst;

  logic        f_flush, f_en, f_rd;
  logic [15:0] f_d, f_data_2;
  logic        f_valid, f_empty, f_full, f_af, f_ae, f_ov, f_un;
  logic [3:0]  f_count;

  logic        r_flush, r_en, r_rd;
  logic [15:0] r_d, r_data_2;
  logic        r_valid, r_empty, r_full, r_af, r_ae, r_ov, r_un;
  logic [3:0]  r_count;

  int errors = 0;
  int checks = 0;

  logic [15:0] q_f[$];
  logic [15:0] q_r[$];
  logic        ov_f, un_f, ov_r, un_r;
  logic [15:0] r_last;

  always #5 clk_1 = ~clk_1;

  sync_fifo_param #(.DATA_W(16), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)) u_fwft (
    .clk_1(clk_1), .rst(rst), .flush(f_flush), .data_1(f_d), .data_1_en(f_en),
    .data_2_rd(f_rd), .data_2(f_data_2), .data_2_valid(f_valid),
    .buffer_empty(f_empty), .buffer_full(f_full), .almost_full(f_af),
    .almost_empty(f_ae), .count(f_count), .overflow(f_ov), .underflow(f_un)
  );

  sync_fifo_param #(.DATA_W(16), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)) u_reg (
    .clk_1(clk_1), .rst(rst), .flush(r_flush), .data_1(r_d), .data_1_en(r_en),
    .data_2_rd(r_rd), .data_2(r_data_2), .data_2_valid(r_valid),
    .buffer_empty(r_empty), .buffer_full(r_full), .almost_full(r_af),
    .almost_empty(r_ae), .count(r_count), .overflow(r_ov), .underflow(r_un)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic status_f();
    int n = q_f.size();
    check("f_count", 32'(f_count), n);
    check("f_empty", 32'(f_empty), 32'(n == 0));
    check("f_full",  32'(f_full),  32'(n == 8));
    check("f_af",    32'(f_af),    32'(n >= 6));
    check("f_ae",    32'(f_ae),    32'(n <= 2));
    check("f_valid", 32'(f_valid), 32'(n != 0));
    check("f_ov",    32'(f_ov),    32'(ov_f));
    check("f_un",    32'(f_un),    32'(un_f));
  endtask

  task automatic status_r();
    int n = q_r.size();
    check("r_count", 32'(r_count), n);
    check("r_empty", 32'(r_empty), 32'(n == 0));
    check("r_full",  32'(r_full),  32'(n == 8));
    check("r_af",    32'(r_af),    32'(n >= 6));
    check("r_ae",    32'(r_ae),    32'(n <= 2));
    check("r_ov",    32'(r_ov),    32'(ov_r));
    check("r_un",    32'(r_un),    32'(un_r));
  endtask

  // One clock on the FWFT instance; head word is checked before the edge.
  task automatic cyc_f(input logic wr, input logic [15:0] d, input logic rd);
    logic rd_ok, wr_ok;
    f_en = wr; f_d = d; f_rd = rd;
    rd_ok = rd && (q_f.size() > 0);
    wr_ok = wr && (q_f.size() < 8);
    if (wr && q_f.size() == 8) ov_f = 1'b1;
    if (rd && q_f.size() == 0) un_f = 1'b1;
    if (rd_ok) check("f_head", 32'(f_data_2), 32'(q_f.pop_front()));
    if (wr_ok) q_f.push_back(d);
    @(posedge clk_1); #1;
    f_en = 1'b0; f_rd = 1'b0;
    status_f();
  endtask

  // One clock on the registered-read instance; popped word is due after the edge.
  task automatic cyc_r(input logic wr, input logic [15:0] d, input logic rd);
    logic rd_ok, wr_ok;
    r_en = wr; r_d = d; r_rd = rd;
    rd_ok = rd && (q_r.size() > 0);
    wr_ok = wr && (q_r.size() < 8);
    if (wr && q_r.size() == 8) ov_r = 1'b1;
    if (rd && q_r.size() == 0) un_r = 1'b1;
    if (rd_ok) r_last = q_r.pop_front();
    if (wr_ok) q_r.push_back(d);
    @(posedge clk_1); #1;
    r_en = 1'b0; r_rd = 1'b0;
    check("r_valid", 32'(r_valid), 32'(rd_ok));
    check("r_data",  32'(r_data_2), 32'(r_last));
    status_r();
  endtask

  task automatic flush_r(input logic wr, input logic rd);
    r_flush = 1'b1; r_en = wr; r_d = 16'hBEEF; r_rd = rd;
    q_r.delete();
    @(posedge clk_1); #1;
    r_flush = 1'b0; r_en = 1'b0; r_rd = 1'b0;
    check("r_flush_valid", 32'(r_valid), 32'd0);
    check("r_flush_data",  32'(r_data_2), 32'(r_last));
    status_r();
  endtask

  initial begin
    rst = 1'b1;
    f_flush = 0; f_en = 0; f_rd = 0; f_d = '0;
    r_flush = 0; r_en = 0; r_rd = 0; r_d = '0;
    ov_f = 0; un_f = 0; ov_r = 0; un_r = 0; r_last = '0;
    #1;
    check("f_rst_data", 32'(f_data_2), 32'd0);
    check("r_rst_data", 32'(r_data_2), 32'd0);
    check("r_rst_valid", 32'(r_valid), 32'd0);
    status_f();
    status_r();
    @(negedge clk_1); rst = 1'b0;

    // fill, overflow pulse, drain
    for (int i = 0; i < 8; i++) cyc_f(1'b1, 16'h1000 + 16'(i), 1'b0);
    cyc_f(1'b1, 16'hDEAD, 1'b0);
    for (int i = 0; i < 8; i++) cyc_f(1'b0, 16'h0, 1'b1);

    // write into empty with a simultaneous read: read refused, write lands
    cyc_f(1'b1, 16'h3000, 1'b1);

    // steady-state concurrency across pointer wrap
    for (int i = 1; i < 4; i++) cyc_f(1'b1, 16'h3000 + 16'(i), 1'b0);
    for (int i = 0; i < 20; i++) cyc_f(1'b1, 16'h2000 + 16'(i), 1'b1);
    cyc_f(1'b0, 16'h0, 1'b1);

    // registered-read instance: flush with requests, flush while empty
    for (int i = 0; i < 5; i++) cyc_r(1'b1, 16'h5000 + 16'(i), 1'b0);
    cyc_r(1'b0, 16'h0, 1'b1);
    flush_r(1'b1, 1'b1);
    flush_r(1'b1, 1'b1);
    cyc_r(1'b1, 16'h0042, 1'b0);
    cyc_r(1'b0, 16'h0, 1'b1);

    // one-cycle read latency, then underflow with data held
    cyc_r(1'b1, 16'h00AA, 1'b0);
    cyc_r(1'b0, 16'h0, 1'b1);
    cyc_r(1'b0, 16'h0, 1'b0);
    cyc_r(1'b0, 16'h0, 1'b1);
    cyc_r(1'b1, 16'h00BB, 1'b1);

    // asynchronous reset between edges with 3 entries held
    check("f_pre_rst_count", 32'(f_count), 32'd3);
    #2 rst = 1'b1;
    #1;
    q_f.delete(); q_r.delete();
    ov_f = 0; un_f = 0; ov_r = 0; un_r = 0; r_last = '0;
    check("f_arst_data", 32'(f_data_2), 32'd0);
    check("r_arst_data", 32'(r_data_2), 32'd0);
    check("r_arst_valid", 32'(r_valid), 32'd0);
    status_f();
    status_r();
    @(negedge clk_1); rst = 1'b0;
    cyc_f(1'b1, 16'h0777, 1'b0);
    cyc_f(1'b0, 16'h0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
